// File: rtl/arbiter_2port_request.sv
// rtl/arbiter_2port_request.sv - two-port round-robin request arbiter feeding the shared memory bus
//
// Grants one of two requesters per cycle and latches the winner into a
// one-entry output register that drives the memory bus. Every granted read
// pushes the winner's type into the response matching FIFO in the grant
// cycle, so returning read data can be routed back to the right port.
//
// Ports:
//   iCLOCK, inRESET        clock, asynchronous active-low reset
//   iFLASH                 synchronous flush of the un-issued output entry
//   iA_* / oA_BUSY         port A (type 0) request, direction, address, data, not-accepted
//   iB_* / oB_BUSY         port B (type 1), same as port A
//   oMEM_* / iMEM_BUSY     registered bus request and bus back-pressure
//   oMATCH_WR_REQ/_TYPE    push of granted read type into the matching FIFO
//   iMATCH_WR_FULL         matching FIFO full; blocks all grants
module arbiter_2port_request #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iFLASH,
  input  logic              iA_REQ,
  output logic              oA_BUSY,
  input  logic              iA_RW,
  input  logic [ADDR_W-1:0] iA_ADDR,
  input  logic [DATA_W-1:0] iA_DATA,
  input  logic              iB_REQ,
  output logic              oB_BUSY,
  input  logic              iB_RW,
  input  logic [ADDR_W-1:0] iB_ADDR,
  input  logic [DATA_W-1:0] iB_DATA,
  output logic              oMEM_REQ,
  input  logic              iMEM_BUSY,
  output logic              oMEM_RW,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_DATA,
  output logic              oMATCH_WR_REQ,
  output logic              oMATCH_WR_TYPE,
  input  logic              iMATCH_WR_FULL
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state;
  state_t stateNext;

  logic              lastB;
  logic              outRw;
  logic [ADDR_W-1:0] outAddr;
  logic [DATA_W-1:0] outData;

  logic              outValid;
  logic              memXfer;
  logic              outFree;
  logic              gntEn;
  logic              grantA;
  logic              grantB;
  logic              grant;
  logic              gntRw;
  logic [ADDR_W-1:0] gntAddr;
  logic [DATA_W-1:0] gntData;

  assign outValid = (state == HOLD);
  assign memXfer  = outValid && !iMEM_BUSY;
  // A slot being emptied by a bus transfer this cycle can be refilled in
  // the same cycle, so back-to-back requests see no bubble.
  assign outFree  = !outValid || !iMEM_BUSY;
  // inRESET gates the grant so both ports read busy and nothing is pushed
  // while reset is held.
  assign gntEn    = inRESET && outFree && !iMATCH_WR_FULL && !iFLASH;

  // On contention last_b picks the port that did not win last time.
  assign grantA = gntEn && iA_REQ && (!iB_REQ || lastB);
  assign grantB = gntEn && iB_REQ && (!iA_REQ || !lastB);
  assign grant  = grantA || grantB;

  assign gntRw   = grantB ? iB_RW   : iA_RW;
  assign gntAddr = grantB ? iB_ADDR : iA_ADDR;
  assign gntData = grantB ? iB_DATA : iA_DATA;

  assign oA_BUSY = !grantA;
  assign oB_BUSY = !grantB;

  assign oMATCH_WR_REQ  = grant && !gntRw;
  assign oMATCH_WR_TYPE = grantB;

  assign oMEM_REQ  = outValid;
  assign oMEM_RW   = outRw;
  assign oMEM_ADDR = outAddr;
  assign oMEM_DATA = outData;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      EMPTY: begin
        if (grant) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        // Flush drops the entry even if the bus is stalled; a grant cannot
        // coincide with flush because gntEn excludes it.
        if (iFLASH) begin
          stateNext = EMPTY;
        end else if (memXfer && !grant) begin
          stateNext = EMPTY;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      lastB   <= 1'b1;
      outRw   <= 1'b0;
      outAddr <= '0;
      outData <= '0;
    end else if (grant) begin
      lastB   <= grantB;
      outRw   <= gntRw;
      outAddr <= gntAddr;
      outData <= gntData;
    end
  end

endmodule

// File: tb/tb_arbiter_2port_request.sv
// tb/tb_arbiter_2port_request.sv - scoreboard testbench for arbiter_2port_request
module tb_arbiter_2port_request;

  logic        iCLOCK;
  logic        inRESET;
  logic        iFLASH;
  logic        iA_REQ;
  logic        oA_BUSY;
  logic        iA_RW;
  logic [31:0] iA_ADDR;
  logic [31:0] iA_DATA;
  logic        iB_REQ;
  logic        oB_BUSY;
  logic        iB_RW;
  logic [31:0] iB_ADDR;
  logic [31:0] iB_DATA;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic        oMEM_RW;
  logic [31:0] oMEM_ADDR;
  logic [31:0] oMEM_DATA;
  logic        oMATCH_WR_REQ;
  logic        oMATCH_WR_TYPE;
  logic        iMATCH_WR_FULL;

  int checks = 0;
  int errors = 0;

  logic [64:0] expBus[$];
  logic        expMatch[$];

  arbiter_2port_request #(.ADDR_W(32), .DATA_W(32)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLASH(iFLASH),
    .iA_REQ(iA_REQ), .oA_BUSY(oA_BUSY), .iA_RW(iA_RW), .iA_ADDR(iA_ADDR), .iA_DATA(iA_DATA),
    .iB_REQ(iB_REQ), .oB_BUSY(oB_BUSY), .iB_RW(iB_RW), .iB_ADDR(iB_ADDR), .iB_DATA(iB_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_RW(oMEM_RW),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .oMATCH_WR_REQ(oMATCH_WR_REQ), .oMATCH_WR_TYPE(oMATCH_WR_TYPE),
    .iMATCH_WR_FULL(iMATCH_WR_FULL)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: compares bus transfers, bus stalls and matching pushes against
  // the expectation queues filled by the stimulus.
  always @(negedge iCLOCK) begin
    if (inRESET) begin
      if (oMATCH_WR_REQ) begin
        if (expMatch.size() == 0) flag("match_unexpected");
        else chk("match_type", {64'd0, oMATCH_WR_TYPE}, {64'd0, expMatch.pop_front()});
      end
      if (oMEM_REQ) begin
        if (expBus.size() == 0) flag("bus_unexpected");
        else if (!iMEM_BUSY) chk("bus_xfer", {oMEM_RW, oMEM_ADDR, oMEM_DATA}, expBus.pop_front());
        else chk("bus_stall", {oMEM_RW, oMEM_ADDR, oMEM_DATA}, expBus[0]);
      end
    end
  end

  // One directed cycle. expGnt: 0 none, 1 port A, 2 port B.
  task automatic runVec(
    input logic aReq, input logic aRw, input logic [31:0] aAddr, input logic [31:0] aData,
    input logic bReq, input logic bRw, input logic [31:0] bAddr, input logic [31:0] bData,
    input logic memBusy, input logic full, input logic flash,
    input logic [1:0] expGnt, input logic chkIdle, input logic dropHeld);
    @(posedge iCLOCK);
    #1;
    iA_REQ = aReq; iA_RW = aRw; iA_ADDR = aAddr; iA_DATA = aData;
    iB_REQ = bReq; iB_RW = bRw; iB_ADDR = bAddr; iB_DATA = bData;
    iMEM_BUSY = memBusy; iMATCH_WR_FULL = full; iFLASH = flash;
    if (expGnt == 2'd1) begin
      expBus.push_back({aRw, aAddr, aData});
      if (!aRw) expMatch.push_back(1'b0);
    end else if (expGnt == 2'd2) begin
      expBus.push_back({bRw, bAddr, bData});
      if (!bRw) expMatch.push_back(1'b1);
    end
    @(negedge iCLOCK);
    #1;
    chk("a_busy", {64'd0, oA_BUSY}, {64'd0, expGnt != 2'd1});
    chk("b_busy", {64'd0, oB_BUSY}, {64'd0, expGnt != 2'd2});
    if (chkIdle) chk("mem_req_idle", {64'd0, oMEM_REQ}, 65'd0);
    // The held entry is discarded by the flush and will never reach the bus.
    if (dropHeld && expBus.size() > 0) void'(expBus.pop_back());
  endtask

  initial begin
    inRESET = 1'b0; iFLASH = 1'b0; iMEM_BUSY = 1'b0; iMATCH_WR_FULL = 1'b0;
    iA_REQ = 1'b1; iA_RW = 1'b0; iA_ADDR = 32'h10; iA_DATA = 32'h0;
    iB_REQ = 1'b1; iB_RW = 1'b0; iB_ADDR = 32'h20; iB_DATA = 32'h0;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst_mem_req", {64'd0, oMEM_REQ}, 65'd0);
    chk("rst_mem_fields", {oMEM_RW, oMEM_ADDR, oMEM_DATA}, 65'd0);
    chk("rst_match_req", {64'd0, oMATCH_WR_REQ}, 65'd0);
    chk("rst_busy", {63'd0, oA_BUSY, oB_BUSY}, 65'd3);
    iA_REQ = 1'b0; iB_REQ = 1'b0;
    @(negedge iCLOCK);
    inRESET = 1'b1;

    //      aReq aRw aAddr        aData         bReq bRw bAddr     bData    busy full flsh gnt idle drop
    runVec(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd0, 1, 0);
    runVec(1, 0, 32'h100, 32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(1, 0, 32'h204, 32'h0,          1, 0, 32'h300, 32'h0,   0, 0, 0, 2'd2, 0, 0);
    runVec(1, 0, 32'h204, 32'h0,          1, 0, 32'h304, 32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(1, 0, 32'h208, 32'h0,          1, 0, 32'h304, 32'h0,   0, 0, 0, 2'd2, 0, 0);
    runVec(1, 0, 32'h208, 32'h0,          1, 0, 32'h308, 32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(0, 0, 32'h0,   32'h0,          1, 1, 32'h20,  32'hDEADBEEF, 0, 0, 0, 2'd2, 0, 0);
    runVec(1, 0, 32'h400, 32'h0,          0, 0, 32'h0,   32'h0,   1, 0, 0, 2'd0, 0, 0);
    runVec(1, 0, 32'h400, 32'h0,          0, 0, 32'h0,   32'h0,   1, 0, 0, 2'd0, 0, 0);
    runVec(1, 0, 32'h400, 32'h0,          0, 0, 32'h0,   32'h0,   1, 0, 0, 2'd0, 0, 0);
    runVec(1, 0, 32'h400, 32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(1, 0, 32'h500, 32'h0,          1, 1, 32'h600, 32'h11,  0, 1, 0, 2'd0, 0, 0);
    runVec(1, 0, 32'h500, 32'h0,          1, 1, 32'h600, 32'h11,  0, 1, 0, 2'd0, 1, 0);
    runVec(1, 0, 32'h500, 32'h0,          1, 1, 32'h600, 32'h11,  0, 0, 0, 2'd2, 0, 0);
    runVec(1, 0, 32'h500, 32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,   32'h0,   1, 0, 0, 2'd0, 0, 0);
    runVec(1, 0, 32'h704, 32'h0,          1, 0, 32'h700, 32'h0,   1, 0, 1, 2'd0, 0, 1);
    runVec(1, 0, 32'h704, 32'h0,          1, 0, 32'h700, 32'h0,   0, 0, 0, 2'd2, 1, 0);
    runVec(1, 0, 32'h704, 32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd0, 0, 0);
    runVec(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd0, 1, 0);
    runVec(1, 0, 32'h800, 32'h0,          0, 0, 32'h0,   32'h0,   0, 0, 0, 2'd1, 0, 0);
    runVec(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,   32'h0,   1, 0, 0, 2'd0, 0, 0);

    // Asynchronous reset while an entry is stalled on the bus.
    iA_REQ = 1'b1; iA_ADDR = 32'h900;
    inRESET = 1'b0;
    #1;
    chk("async_rst_mem_req", {64'd0, oMEM_REQ}, 65'd0);
    chk("async_rst_a_busy", {64'd0, oA_BUSY}, 65'd1);
    if (expBus.size() > 0) void'(expBus.pop_back());
    chk("bus_queue_drained", 65'(expBus.size()), 65'd0);
    chk("match_queue_drained", 65'(expMatch.size()), 65'd0);
    iA_REQ = 1'b0;
    @(negedge iCLOCK);
    inRESET = 1'b1;
    repeat (2) @(posedge iCLOCK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
